// File: rtl/sa_dataflow_ctrl_if.sv
// Bus bundle between the systolic-array dataflow sequencer and its BRAMs / array.
// The master side is the sequencer; the slave side is the BRAM + array fabric.
interface sa_dataflow_ctrl_if #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 4
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                      start;
    logic [ADDR_WIDTH:0]       k_len;
    logic                      busy;
    logic                      done;
    logic                      iact_en;
    logic [ADDR_WIDTH-1:0]     iact_addr;
    logic [ROWS*WORD_SIZE-1:0] iact_dout;
    logic                      wt_en;
    logic [ADDR_WIDTH-1:0]     wt_addr;
    logic [COLS*WORD_SIZE-1:0] wt_dout;
    logic                      arr_clear;
    logic [ROWS*WORD_SIZE-1:0] arr_iact;
    logic [ROWS-1:0]           arr_iact_valid;
    logic [COLS*WORD_SIZE-1:0] arr_wt;
    logic [COLS-1:0]           arr_wt_valid;
    logic [RW-1:0]             arr_rd_row;
    logic [COLS*WORD_SIZE-1:0] arr_rd_data;
    logic                      oact_we;
    logic [ADDR_WIDTH-1:0]     oact_addr;
    logic [COLS*WORD_SIZE-1:0] oact_din;

    modport master (
        input  start, k_len, iact_dout, wt_dout, arr_rd_data,
        output busy, done, iact_en, iact_addr, wt_en, wt_addr, arr_clear,
               arr_iact, arr_iact_valid, arr_wt, arr_wt_valid, arr_rd_row,
               oact_we, oact_addr, oact_din
    );

    modport slave (
        output start, k_len, iact_dout, wt_dout, arr_rd_data,
        input  busy, done, iact_en, iact_addr, wt_en, wt_addr, arr_clear,
               arr_iact, arr_iact_valid, arr_wt, arr_wt_valid, arr_rd_row,
               oact_we, oact_addr, oact_din
    );
endinterface

// File: rtl/sa_dataflow_ctrl.sv
// Sequencer feeding an output-stationary systolic array from iact/wt BRAMs with
// diagonal skew, waiting for drain, then writing accumulator rows to oact BRAM.
module sa_dataflow_ctrl #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int WORD_SIZE    = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int DRAIN_CYCLES = ROWS + COLS
) (
    input  logic               clk,
    input  logic               rst,
    sa_dataflow_ctrl_if.master bus
);
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int MAX_RC    = (ROWS > COLS) ? ROWS : COLS;
    localparam int DRAIN_LEN = MAX_RC + 1 + DRAIN_CYCLES;
    localparam int K_MAX     = 2 ** ADDR_WIDTH;
    localparam int TOP_A     = (K_MAX > DRAIN_LEN) ? K_MAX : DRAIN_LEN;
    localparam int CNT_TOP   = (TOP_A > ROWS) ? TOP_A : ROWS;
    localparam int CNT_W     = $clog2(CNT_TOP + 1);

    typedef enum logic [2:0] {S_IDLE, S_FEED, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   k_q, k_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  en_q, en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  clear_q, clear_d;
    logic [RW-1:0]         rd_row_q, rd_row_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] oaddr_q, oaddr_d;
    logic                  rd_vld_q, rd_vld_d;

    logic [ROWS*WORD_SIZE-1:0] arr_iact_w;
    logic [ROWS-1:0]           arr_iact_vld_w;
    logic [COLS*WORD_SIZE-1:0] arr_wt_w;
    logic [COLS-1:0]           arr_wt_vld_w;

    // Requests beyond the BRAM depth are clamped so the read address never wraps.
    function automatic logic [ADDR_WIDTH:0] clamp_k(input logic [ADDR_WIDTH:0] k);
        if (k > (ADDR_WIDTH+1)'(K_MAX))
            return (ADDR_WIDTH+1)'(K_MAX);
        return k;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    k_d     = clamp_k(bus.k_len);
                    cnt_d   = '0;
                    state_d = (bus.k_len == '0) ? S_DONE : S_FEED;
                end
            end
            S_FEED: begin
                if (cnt_q == CNT_W'(k_q) - CNT_W'(1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_W'(DRAIN_LEN - 1)) begin
                    state_d = S_WRITE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (cnt_q == CNT_W'(ROWS - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up
    // with state_q; the clear fires on leaving IDLE, including the empty job.
    always_comb begin
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        en_d     = (state_d == S_FEED);
        addr_d   = (state_d == S_FEED) ? cnt_d[ADDR_WIDTH-1:0] : '0;
        clear_d  = (state_q == S_IDLE) && (state_d != S_IDLE);
        we_d     = (state_d == S_WRITE);
        oaddr_d  = (state_d == S_WRITE) ? cnt_d[ADDR_WIDTH-1:0] : '0;
        rd_row_d = (state_d == S_WRITE) ? cnt_d[RW-1:0] : '0;
        rd_vld_d = en_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            en_q     <= 1'b0;
            addr_q   <= '0;
            clear_q  <= 1'b0;
            we_q     <= 1'b0;
            oaddr_q  <= '0;
            rd_row_q <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            en_q     <= en_d;
            addr_q   <= addr_d;
            clear_q  <= clear_d;
            we_q     <= we_d;
            oaddr_q  <= oaddr_d;
            rd_row_q <= rd_row_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    // Lane r is delayed r+1 cycles past the BRAM read data to form the diagonal.
    for (genvar r = 0; r < ROWS; r++) begin : g_iact_lane
        logic [WORD_SIZE-1:0] sk_q [0:r];
        logic [WORD_SIZE-1:0] sk_d [0:r];
        logic [r:0]           vld_q, vld_d;

        always_comb begin
            sk_d[0]  = rd_vld_q ? bus.iact_dout[r*WORD_SIZE +: WORD_SIZE] : '0;
            vld_d[0] = rd_vld_q;
            for (int j = 1; j <= r; j++) begin
                sk_d[j]  = sk_q[j-1];
                vld_d[j] = vld_q[j-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= r; j++) sk_q[j] <= '0;
                vld_q <= '0;
            end else begin
                sk_q  <= sk_d;
                vld_q <= vld_d;
            end
        end

        assign arr_iact_w[r*WORD_SIZE +: WORD_SIZE] = sk_q[r];
        assign arr_iact_vld_w[r]                    = vld_q[r];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_wt_lane
        logic [WORD_SIZE-1:0] sk_q [0:c];
        logic [WORD_SIZE-1:0] sk_d [0:c];
        logic [c:0]           vld_q, vld_d;

        always_comb begin
            sk_d[0]  = rd_vld_q ? bus.wt_dout[c*WORD_SIZE +: WORD_SIZE] : '0;
            vld_d[0] = rd_vld_q;
            for (int j = 1; j <= c; j++) begin
                sk_d[j]  = sk_q[j-1];
                vld_d[j] = vld_q[j-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= c; j++) sk_q[j] <= '0;
                vld_q <= '0;
            end else begin
                sk_q  <= sk_d;
                vld_q <= vld_d;
            end
        end

        assign arr_wt_w[c*WORD_SIZE +: WORD_SIZE] = sk_q[c];
        assign arr_wt_vld_w[c]                    = vld_q[c];
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.iact_en        = en_q;
    assign bus.iact_addr      = addr_q;
    assign bus.wt_en          = en_q;
    assign bus.wt_addr        = addr_q;
    assign bus.arr_clear      = clear_q;
    assign bus.arr_iact       = arr_iact_w;
    assign bus.arr_iact_valid = arr_iact_vld_w;
    assign bus.arr_wt         = arr_wt_w;
    assign bus.arr_wt_valid   = arr_wt_vld_w;
    assign bus.arr_rd_row     = rd_row_q;
    assign bus.oact_we        = we_q;
    assign bus.oact_addr      = oaddr_q;
    assign bus.oact_din       = bus.arr_rd_data;
endmodule

// File: tb/tb_sa_dataflow_ctrl.sv
// Scoreboard bench for sa_dataflow_ctrl: jobs push expectations, one monitor
// process pops and compares whatever the DUT presents each cycle.
module tb_sa_dataflow_ctrl;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int W    = 16;
    localparam int AW   = 4;
    localparam int DRAIN_LEN = 4 + 1 + 8;

    typedef struct packed {
        logic [7:0]  lane;
        logic [15:0] off;
        logic [15:0] data;
    } lane_t;

    typedef struct packed {
        logic [AW-1:0]     addr;
        logic [COLS*W-1:0] din;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sa_dataflow_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W), .ADDR_WIDTH(AW)) bus ();

    sa_dataflow_ctrl #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [ROWS*W-1:0] iact_mem [16];
    logic [COLS*W-1:0] wt_mem   [16];

    always @(posedge clk) begin
        if (bus.iact_en) bus.iact_dout <= iact_mem[bus.iact_addr];
        if (bus.wt_en)   bus.wt_dout   <= wt_mem[bus.wt_addr];
    end

    assign bus.arr_rd_data = {COLS{W'(bus.arr_rd_row)}};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    lane_t         iq[$];
    lane_t         wq[$];
    logic [AW-1:0] rdq[$];
    wr_t           wrq[$];
    int            busyq[$];
    bit            clrq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no matching expectation (cycle %0d)", name, cyc);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},      64'(bus.busy), 0);
        check({tag, "_done"},      64'(bus.done), 0);
        check({tag, "_iact_en"},   64'(bus.iact_en), 0);
        check({tag, "_iact_addr"}, 64'(bus.iact_addr), 0);
        check({tag, "_wt_en"},     64'(bus.wt_en), 0);
        check({tag, "_wt_addr"},   64'(bus.wt_addr), 0);
        check({tag, "_clear"},     64'(bus.arr_clear), 0);
        check({tag, "_arr_iact"},  64'(bus.arr_iact), 0);
        check({tag, "_iact_vld"},  64'(bus.arr_iact_valid), 0);
        check({tag, "_arr_wt"},    64'(bus.arr_wt), 0);
        check({tag, "_wt_vld"},    64'(bus.arr_wt_valid), 0);
        check({tag, "_rd_row"},    64'(bus.arr_rd_row), 0);
        check({tag, "_oact_we"},   64'(bus.oact_we), 0);
        check({tag, "_oact_addr"}, 64'(bus.oact_addr), 0);
    endtask

    // Expected lane word t: iact = 16*t + lane, wt = 0x100 + 16*t + lane.
    task automatic push_job(input int k, input int max_off, input bit full);
        int ke;
        lane_t e;
        wr_t w;
        ke = (k > 16) ? 16 : k;
        clrq.push_back(ke > 0);
        for (int a = 0; a < ke; a++) rdq.push_back(AW'(a));
        for (int off = 2; off <= ke + 1 + ROWS; off++) begin
            for (int r = 0; r < ROWS; r++) begin
                int t;
                t = off - 2 - r;
                if (t >= 0 && t < ke && off <= max_off) begin
                    e.lane = 8'(r); e.off = 16'(off); e.data = 16'(16 * t + r);
                    iq.push_back(e);
                    e.data = 16'(256 + 16 * t + r);
                    wq.push_back(e);
                end
            end
        end
        if (full) begin
            if (ke > 0) begin
                for (int a = 0; a < ROWS; a++) begin
                    w.addr = AW'(a);
                    w.din  = {COLS{16'(a)}};
                    wrq.push_back(w);
                end
                busyq.push_back(ke + DRAIN_LEN + ROWS + 1);
            end else begin
                busyq.push_back(1);
            end
        end
    endtask

    task automatic wait_done(input int tgt, input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc && done_cnt < tgt; i++) @(posedge clk);
        if (done_cnt < tgt) unexpected({tag, "_done_timeout"});
    endtask

    // Monitor: everything the DUT presents is matched against the queues.
    initial begin : monitor
        int busy_len;
        int f_cyc;
        busy_len = 0;
        f_cyc = 0;
        forever begin
            @(negedge clk);
            if (bus.arr_clear) begin
                if (clrq.size() == 0) unexpected("arr_clear");
                else check("clear_with_feed", 64'(bus.iact_en), 64'(clrq.pop_front()));
                f_cyc = cyc;
            end
            if (bus.iact_en || bus.wt_en) begin
                if (rdq.size() == 0) unexpected("bram_read");
                else begin
                    logic [AW-1:0] a;
                    a = rdq.pop_front();
                    check("iact_en",   64'(bus.iact_en), 1);
                    check("wt_en",     64'(bus.wt_en), 1);
                    check("iact_addr", 64'(bus.iact_addr), 64'(a));
                    check("wt_addr",   64'(bus.wt_addr), 64'(a));
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                if (bus.arr_iact_valid[r]) begin
                    if (iq.size() == 0) unexpected("iact_lane");
                    else begin
                        lane_t e;
                        e = iq.pop_front();
                        check("iact_lane", 64'(r), 64'(e.lane));
                        check("iact_skew", 64'(cyc - f_cyc), 64'(e.off));
                        check("iact_data", 64'(bus.arr_iact[r*W +: W]), 64'(e.data));
                    end
                end else begin
                    check("iact_idle_zero", 64'(bus.arr_iact[r*W +: W]), 0);
                end
                if (bus.arr_wt_valid[r]) begin
                    if (wq.size() == 0) unexpected("wt_lane");
                    else begin
                        lane_t e;
                        e = wq.pop_front();
                        check("wt_lane", 64'(r), 64'(e.lane));
                        check("wt_skew", 64'(cyc - f_cyc), 64'(e.off));
                        check("wt_data", 64'(bus.arr_wt[r*W +: W]), 64'(e.data));
                    end
                end else begin
                    check("wt_idle_zero", 64'(bus.arr_wt[r*W +: W]), 0);
                end
            end
            if (bus.oact_we) begin
                if (wrq.size() == 0) unexpected("oact_write");
                else begin
                    wr_t w;
                    w = wrq.pop_front();
                    check("oact_addr", 64'(bus.oact_addr), 64'(w.addr));
                    check("oact_din",  64'(bus.oact_din), 64'(w.din));
                end
            end
            if (bus.busy) busy_len++;
            if (bus.done) begin
                if (busyq.size() == 0) unexpected("done_pulse");
                else check("busy_cycles", 64'(busy_len), 64'(busyq.pop_front()));
                done_cnt++;
                busy_len = 0;
            end
            if (!bus.busy) busy_len = 0;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int tgt;
        int guard;
        for (int t = 0; t < 16; t++) begin
            for (int r = 0; r < ROWS; r++) begin
                iact_mem[t][r*W +: W] = 16'(16 * t + r);
                wt_mem[t][r*W +: W]   = 16'(256 + 16 * t + r);
            end
        end
        rst = 1'b1;
        bus.start = 1'b0;
        bus.k_len = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_zero("reset_idle");

        // k_len = 3: reads 0..2, skewed lanes, four row writes, 21 busy cycles.
        tgt = done_cnt + 1;
        push_job(3, 1000, 1'b1);
        bus.start = 1'b1; bus.k_len = 5'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(tgt, 100, "k3");
        @(negedge clk);
        check("k3_idle_busy", 64'(bus.busy), 0);

        // k_len = 0: straight to DONE with a clear pulse and no traffic.
        tgt = done_cnt + 1;
        push_job(0, 1000, 1'b1);
        bus.start = 1'b1; bus.k_len = 5'd0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(tgt, 10, "k0");
        @(negedge clk);
        check("k0_idle_busy", 64'(bus.busy), 0);

        // Reset during the second DRAIN cycle abandons the job.
        push_job(2, 3, 1'b0);
        bus.start = 1'b1; bus.k_len = 5'd2;
        @(negedge clk);
        bus.start = 1'b0;
        guard = 0;
        while (!bus.iact_en && guard < 20) begin @(negedge clk); guard++; end
        while (bus.iact_en && guard < 40) begin @(negedge clk); guard++; end
        if (guard >= 40) unexpected("abort_feed_timeout");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("abort");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        tgt = done_cnt + 1;
        push_job(1, 1000, 1'b1);
        bus.start = 1'b1; bus.k_len = 5'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(tgt, 100, "k1");
        @(negedge clk);

        // k_len = 20 clamps to 16; start held so a second job follows from IDLE.
        tgt = done_cnt + 1;
        push_job(20, 1000, 1'b1);
        push_job(20, 1000, 1'b1);
        bus.start = 1'b1; bus.k_len = 5'd20;
        wait_done(tgt, 200, "k20a");
        @(negedge clk);
        check("k20_idle_gap_busy", 64'(bus.busy), 0);
        tgt = done_cnt + 1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(tgt, 200, "k20b");
        repeat (5) @(negedge clk);

        check("left_reads",  64'(rdq.size()), 0);
        check("left_iact",   64'(iq.size()), 0);
        check("left_wt",     64'(wq.size()), 0);
        check("left_writes", 64'(wrq.size()), 0);
        check("left_busy",   64'(busyq.size()), 0);
        check("left_clear",  64'(clrq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sa_dataflow_ctrl.md
Name: sa_dataflow_ctrl

Overview:
Parametrised sequencer between the three BRAMs (iact, wt, oact) and an output-stationary ROWS x COLS systolic array. On start it streams k_len input-activation and weight vectors from BRAM into the array with diagonal skew, waits for the array to drain, then writes every accumulator row back to oact BRAM. It generalises the fixed 4x4 top-level BRAM wiring with runtime depth, skewing, and a controlling state machine.

Parameters:
ROWS, 4, array rows / iact lanes
COLS, 4, array columns / wt lanes
WORD_SIZE, 16, bits per element
ADDR_WIDTH, 4, BRAM address width; max k_len = 2**ADDR_WIDTH
DRAIN_CYCLES, ROWS+COLS, cycles from last skewed element leaving the controller to results being stable

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a matmul; sampled only in IDLE
k_len  in  ADDR_WIDTH+1  vectors to stream; sampled with start
busy  out  1  high in every non-IDLE state
done  out  1  one-cycle pulse in DONE
iact_en  out  1  iact BRAM read enable
iact_addr  out  ADDR_WIDTH  iact read address
iact_dout  in  ROWS*WORD_SIZE  iact read data, 1-cycle BRAM latency
wt_en  out  1  wt BRAM read enable
wt_addr  out  ADDR_WIDTH  wt read address
wt_dout  in  COLS*WORD_SIZE  wt read data, 1-cycle latency
arr_clear  out  1  one-cycle accumulator clear to array
arr_iact  out  ROWS*WORD_SIZE  skewed activations, lane r = bits [r*WORD_SIZE +: WORD_SIZE]
arr_iact_valid  out  ROWS  per-lane valid
arr_wt  out  COLS*WORD_SIZE  skewed weights
arr_wt_valid  out  COLS  per-lane valid
arr_rd_row  out  $clog2(ROWS)  array result row select
arr_rd_data  in  COLS*WORD_SIZE  selected row results, combinational from array
oact_we  out  1  oact BRAM write enable
oact_addr  out  ADDR_WIDTH  oact write address
oact_din  out  COLS*WORD_SIZE  oact write data

Behaviour:
- States: IDLE, FEED, DRAIN, WRITE, DONE. All outputs registered except oact_din (= arr_rd_data).
- Reset (any state, mid-operation included): state IDLE, all outputs 0, all skew registers and valids cleared, counters 0; in-flight job abandoned, no partial writes after rst edge.
- IDLE: start=1 and k_len!=0 -> FEED, cnt=0, k latched. start=1 and k_len=0 -> DONE directly (arr_clear pulsed, no BRAM access, no writes). start ignored outside IDLE.
- FEED (k cycles): arr_clear=1 in first FEED cycle only; iact_en=wt_en=1, iact_addr=wt_addr=cnt, cnt++; after cnt=k-1 -> DRAIN.
- Skew: with F = first FEED cycle, element t of iact lane r appears on arr_iact lane r with valid=1 in cycle F+2+t+r; wt lane c in cycle F+2+t+c. Lanes output data 0 and valid 0 when no element present.
- DRAIN: counter runs max(ROWS,COLS)+1+DRAIN_CYCLES cycles, then WRITE with cnt=0.
- WRITE (ROWS cycles): arr_rd_row=cnt, oact_we=1, oact_addr=cnt, oact_din=arr_rd_data; after row ROWS-1 -> DONE.
- DONE: done=1, busy=1 for one cycle -> IDLE. start in DONE ignored.
- k_len > 2**ADDR_WIDTH clamped to 2**ADDR_WIDTH; address never wraps.
- Busy duration for k>0: k + max(ROWS,COLS)+1+DRAIN_CYCLES + ROWS + 1 cycles.

Test Plan:
- Reset then idle 10 cycles -> every output 0, busy 0, no en/we activity.
- Defaults, k_len=3, iact word t lane r = 16*t+r -> iact_addr 0,1,2 in FEED; arr_iact lane 2 shows 0x0002,0x0012,0x0022 at F+4..F+6, valid low elsewhere; done after 3+5+8+4+1=21 busy cycles.
- Same job with arr_rd_data = {row idx replicated} -> oact_we high 4 cycles, oact_addr 0..3, oact_din 0x0000..0x0003 per lane, single done pulse.
- k_len=0 -> busy 1 cycle, done pulse next cycle, arr_clear pulse, no iact_en/oact_we.
- rst asserted in cycle 2 of DRAIN -> next cycle IDLE, outputs 0; new start k_len=1 completes normally.
- start held high through job and k_len=20 with ADDR_WIDTH=4 -> exactly 16 reads (addr 0..15), no restart until IDLE, second job begins only from IDLE.
